// File: rtl/apu_link_pkg.sv
// -----------------------------------------------------------------------------
// apu_link_pkg
// Constants, state type and frame helpers for the APU register serial link.
// The encoder and the decoder in the sound block both import this package.
// Frame layout on the wire, LSB first: START, data[3:0], addr[3:0], STOP.
// -----------------------------------------------------------------------------
package apu_link_pkg;

    localparam int   FRAME_WIDTH = 10;
    localparam logic START       = 1'b0;
    localparam logic STOP        = 1'b1;
    localparam int   NUM_REGS    = 8;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_IDLE,
        ST_WAIT,
        ST_LO,
        ST_HI,
        ST_GAP
    } apu_state_t;

    // Payload {addr_nibble, data_nibble}; addr_nibble = {k, hi_select}.
    function automatic logic [7:0] apu_payload(input logic [2:0] k,
                                               input logic       hi_select,
                                               input logic [7:0] value);
        apu_payload = {k, hi_select, (hi_select ? value[7:4] : value[3:0])};
    endfunction

    // Complete frame; bit 0 goes on the wire first.
    function automatic logic [FRAME_WIDTH-1:0] apu_frame(input logic [2:0] k,
                                                         input logic       hi_select,
                                                         input logic [7:0] value);
        apu_frame = {STOP, apu_payload(k, hi_select, value), START};
    endfunction

endpackage

// File: rtl/apu_sck_gen.sv
// -----------------------------------------------------------------------------
// apu_sck_gen
// Free-running serial clock for the APU register link.
//   i_clk        system clock
//   i_rst        asynchronous active-high reset
//   o_sck        serial clock, period 2*DIV clk, low out of reset
//   o_fall_tick  high in the clk cycle whose rising edge takes o_sck 1->0
// -----------------------------------------------------------------------------
module apu_sck_gen #(
    parameter int DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_sck,
    output logic o_fall_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_div;
    logic          r_sck;
    logic          w_wrap;

    assign w_wrap = (r_div == CW'(DIV - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div <= '0;
            r_sck <= 1'b0;
        end else if (w_wrap) begin
            r_div <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign o_sck       = r_sck;
    assign o_fall_tick = w_wrap & r_sck;

endmodule

// File: rtl/apu_reg_encoder.sv
// -----------------------------------------------------------------------------
// apu_reg_encoder
// Serial transmitter for the APU register link. Each accepted 8-bit register
// write is sent as two back-to-back 10-bit frames: low nibble to address 2k,
// then high nibble to address 2k+1 (the receiver commits on the odd address).
//   clk       system clock
//   rst       asynchronous active-high reset
//   wr_valid  write request present
//   wr_ready  request accepted on this clk edge when wr_valid is high
//   wr_addr   target register index k (0..7)
//   wr_data   register value
//   sck       serial clock, free-running; receiver samples sdo on rising sck
//   sdo       serial data, updated only on falling sck
//   busy      high during SYNC and from accept to the end of the gap
// -----------------------------------------------------------------------------
module apu_reg_encoder
    import apu_link_pkg::*;
#(
    parameter int DIV       = 4,
    parameter int SYNC_BITS = 12,
    parameter int GAP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       sck,
    output logic       sdo,
    output logic       busy
);

    localparam int IDLE_MAX = (SYNC_BITS > GAP_BITS) ? SYNC_BITS : GAP_BITS;
    localparam int ICW      = $clog2(IDLE_MAX + 1);

    apu_state_t             r_state,    w_state_n;
    logic                   r_sdo,      w_sdo_n;
    logic [3:0]             r_bit_cnt,  w_bit_cnt_n;
    logic [ICW-1:0]         r_idle_cnt, w_idle_cnt_n;
    logic [FRAME_WIDTH-2:0] r_shift,    w_shift_n;
    logic [2:0]             r_addr,     w_addr_n;
    logic [7:0]             r_data,     w_data_n;

    logic                   w_fall;
    logic                   w_last_bit;
    logic [FRAME_WIDTH-1:0] w_frame_lo;
    logic [FRAME_WIDTH-1:0] w_frame_hi;

    apu_sck_gen #(
        .DIV (DIV)
    ) u_sck_gen (
        .i_clk       (clk),
        .i_rst       (rst),
        .o_sck       (sck),
        .o_fall_tick (w_fall)
    );

    assign w_frame_lo = apu_frame(r_addr, 1'b0, r_data);
    assign w_frame_hi = apu_frame(r_addr, 1'b1, r_data);
    assign w_last_bit = (r_bit_cnt == 4'(FRAME_WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_SYNC;
            r_sdo      <= STOP;
            r_bit_cnt  <= '0;
            r_idle_cnt <= '0;
            r_shift    <= '0;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            r_state    <= w_state_n;
            r_sdo      <= w_sdo_n;
            r_bit_cnt  <= w_bit_cnt_n;
            r_idle_cnt <= w_idle_cnt_n;
            r_shift    <= w_shift_n;
            r_addr     <= w_addr_n;
            r_data     <= w_data_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_sdo_n      = r_sdo;
        w_bit_cnt_n  = r_bit_cnt;
        w_idle_cnt_n = r_idle_cnt;
        w_shift_n    = r_shift;
        w_addr_n     = r_addr;
        w_data_n     = r_data;

        unique case (r_state)
            ST_SYNC: begin
                w_sdo_n = STOP;
                if (w_fall) begin
                    if (int'(r_idle_cnt) == SYNC_BITS - 1) begin
                        w_state_n    = ST_IDLE;
                        w_idle_cnt_n = '0;
                    end else begin
                        w_idle_cnt_n = r_idle_cnt + 1'b1;
                    end
                end
            end

            ST_IDLE: begin
                w_sdo_n = STOP;
                // Holding registers load only here, so they are frozen while busy.
                if (wr_valid) begin
                    w_addr_n  = wr_addr;
                    w_data_n  = wr_data;
                    w_state_n = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (w_fall) begin
                    w_sdo_n     = w_frame_lo[0];
                    w_shift_n   = w_frame_lo[FRAME_WIDTH-1:1];
                    w_bit_cnt_n = '0;
                    w_state_n   = ST_LO;
                end
            end

            ST_LO: begin
                if (w_fall) begin
                    if (w_last_bit) begin
                        // Stop bit has been held a full period: chain straight into HI.
                        w_sdo_n     = w_frame_hi[0];
                        w_shift_n   = w_frame_hi[FRAME_WIDTH-1:1];
                        w_bit_cnt_n = '0;
                        w_state_n   = ST_HI;
                    end else begin
                        w_sdo_n     = r_shift[0];
                        w_shift_n   = {STOP, r_shift[FRAME_WIDTH-2:1]};
                        w_bit_cnt_n = r_bit_cnt + 1'b1;
                    end
                end
            end

            ST_HI: begin
                if (w_fall) begin
                    if (w_last_bit) begin
                        w_sdo_n      = STOP;
                        w_bit_cnt_n  = '0;
                        w_idle_cnt_n = '0;
                        w_state_n    = (GAP_BITS == 0) ? ST_IDLE : ST_GAP;
                    end else begin
                        w_sdo_n     = r_shift[0];
                        w_shift_n   = {STOP, r_shift[FRAME_WIDTH-2:1]};
                        w_bit_cnt_n = r_bit_cnt + 1'b1;
                    end
                end
            end

            ST_GAP: begin
                w_sdo_n = STOP;
                if (w_fall) begin
                    if (int'(r_idle_cnt) == GAP_BITS - 1) begin
                        w_state_n    = ST_IDLE;
                        w_idle_cnt_n = '0;
                    end else begin
                        w_idle_cnt_n = r_idle_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_sdo_n   = STOP;
                w_state_n = ST_SYNC;
            end
        endcase
    end

    assign wr_ready = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);
    assign sdo      = r_sdo;

endmodule

// File: tb/tb_apu_reg_encoder.sv
// -----------------------------------------------------------------------------
// tb_apu_reg_encoder
// Drives two encoders (DIV=4 and DIV=1) and decodes their serial output with a
// behavioural model of the APU register decoder. Expected frames are queued at
// accept time and compared as the model receives them.
// -----------------------------------------------------------------------------
module tb_apu_reg_encoder;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_v   = 2'b11;
    logic [1:0] valid_v = 2'b00;
    logic [1:0] ready_v;
    logic [1:0] sck_v;
    logic [1:0] sdo_v;
    logic [1:0] busy_v;
    logic [2:0] addr_v [2];
    logic [7:0] data_v [2];

    int tests = 0;
    int fails = 0;

    // {dut_sel, addr_nibble, data_nibble}
    logic [8:0] exp_q [$];

    // Decoder model state, one set per DUT
    logic [7:0] dec_regs [2][8];
    int         commits  [2];
    logic       dec_prev [2];
    logic       dec_in   [2];
    int         dec_pos  [2];
    logic [7:0] dec_sh   [2];
    logic       lo_valid [2];
    logic [2:0] lo_k     [2];
    logic [3:0] lo_nib   [2];

    apu_reg_encoder #(
        .DIV       (4),
        .SYNC_BITS (12),
        .GAP_BITS  (1)
    ) u_dut_a (
        .clk      (clk),
        .rst      (rst_v[0]),
        .wr_valid (valid_v[0]),
        .wr_ready (ready_v[0]),
        .wr_addr  (addr_v[0]),
        .wr_data  (data_v[0]),
        .sck      (sck_v[0]),
        .sdo      (sdo_v[0]),
        .busy     (busy_v[0])
    );

    apu_reg_encoder #(
        .DIV       (1),
        .SYNC_BITS (12),
        .GAP_BITS  (1)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst_v[1]),
        .wr_valid (valid_v[1]),
        .wr_ready (ready_v[1]),
        .wr_addr  (addr_v[1]),
        .wr_data  (data_v[1]),
        .sck      (sck_v[1]),
        .sdo      (sdo_v[1]),
        .busy     (busy_v[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural decoder: hunts for a start bit, takes 8 payload bits LSB-first,
    // checks the stop bit, latches the even-address nibble and commits on odd.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_v[i]) begin
                dec_prev[i] = 1'b0;
                dec_in[i]   = 1'b0;
                dec_pos[i]  = 0;
                lo_valid[i] = 1'b0;
            end else begin
                if (sck_v[i] && !dec_prev[i]) begin
                    if (!dec_in[i]) begin
                        if (sdo_v[i] == 1'b0) begin
                            dec_in[i]  = 1'b1;
                            dec_pos[i] = 0;
                        end
                    end else if (dec_pos[i] < 8) begin
                        dec_sh[i][dec_pos[i]] = sdo_v[i];
                        dec_pos[i]++;
                    end else begin
                        dec_in[i] = 1'b0;
                        check("stop_bit", 32'(sdo_v[i]), 32'd1);
                        check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                        if (exp_q.size() > 0)
                            check("frame_bits", 32'({(i == 1), dec_sh[i]}), 32'(exp_q.pop_front()));
                        if (!dec_sh[i][4]) begin
                            lo_valid[i] = 1'b1;
                            lo_k[i]     = dec_sh[i][7:5];
                            lo_nib[i]   = dec_sh[i][3:0];
                        end else begin
                            if (lo_valid[i] && lo_k[i] == dec_sh[i][7:5]) begin
                                dec_regs[i][lo_k[i]] = {dec_sh[i][3:0], lo_nib[i]};
                                commits[i]++;
                            end
                            lo_valid[i] = 1'b0;
                        end
                    end
                end
                dec_prev[i] = sck_v[i];
            end
        end
    end

    // Called just after a negedge. Pushes the two expected frames before the
    // accept edge; returns at the negedge following it.
    task automatic do_write(input int sel, input logic [2:0] k, input logic [7:0] d,
                            input bit hold, output time acc_t);
        int n;
        n = 0;
        valid_v[sel] = 1'b1;
        addr_v[sel]  = k;
        data_v[sel]  = d;
        while (!ready_v[sel] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(ready_v[sel]), 32'd1);
        if (ready_v[sel]) begin
            exp_q.push_back({(sel == 1), k, 1'b0, d[3:0]});
            exp_q.push_back({(sel == 1), k, 1'b1, d[7:4]});
        end
        @(posedge clk);
        @(negedge clk);
        acc_t = $time;
        if (!hold) valid_v[sel] = 1'b0;
    endtask

    task automatic check_latency(input int sel, input int div);
        int k;
        k = 0;
        while (sdo_v[sel] !== 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("start_latency", 32'(k >= 1 && k <= 2 * div), 32'd1);
    endtask

    task automatic wait_idle(input int sel);
        int n;
        n = 0;
        while (busy_v[sel] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 32'(busy_v[sel]), 32'd0);
    endtask

    // Called at the negedge where rst was released.
    task automatic sync_check(input int sel, input int div);
        int   n, rises, last, intervals;
        logic prev, ones;
        n = 0; rises = 0; last = -1; intervals = 0;
        prev = sck_v[sel];
        ones = 1'b1;
        while (!ready_v[sel] && n < 5000) begin
            @(negedge clk);
            n++;
            if (sck_v[sel] !== prev) begin
                if (last >= 0 && intervals < 4) begin
                    check("sck_half_period", 32'(n - last), 32'(div));
                    intervals++;
                end
                last = n;
                if (sck_v[sel]) rises++;
                prev = sck_v[sel];
            end
            if (sdo_v[sel] !== 1'b1) ones = 1'b0;
        end
        check("sync_ready", 32'(ready_v[sel]), 32'd1);
        check("sync_bit_periods", 32'(rises), 32'd12);
        check("sync_sdo_idle", 32'(ones), 32'd1);
    endtask

    task automatic check_reset_outputs(input int sel);
        check("rst_sck", 32'(sck_v[sel]), 32'd0);
        check("rst_sdo", 32'(sdo_v[sel]), 32'd1);
        check("rst_ready", 32'(ready_v[sel]), 32'd0);
        check("rst_busy", 32'(busy_v[sel]), 32'd1);
    endtask

    initial begin
        time  t1, t2;
        int   n, r;
        logic prev;

        for (int i = 0; i < 2; i++) begin
            addr_v[i]  = '0;
            data_v[i]  = '0;
            commits[i] = 0;
            for (int j = 0; j < 8; j++) dec_regs[i][j] = '0;
        end

        repeat (3) @(negedge clk);
        check_reset_outputs(0);
        check_reset_outputs(1);

        // DUT A: SYNC after reset release
        rst_v[0] = 1'b0;
        sync_check(0, 4);

        // k=2, 0xA5
        do_write(0, 3'd2, 8'hA5, 1'b0, t1);
        check_latency(0, 4);
        wait_idle(0);
        check("reg2_a5", 32'(dec_regs[0][2]), 32'hA5);
        check("commits_1", 32'(commits[0]), 32'd1);

        // k=7 0xFF then k=0 0x00 with wr_valid held throughout
        do_write(0, 3'd7, 8'hFF, 1'b1, t1);
        do_write(0, 3'd0, 8'h00, 1'b0, t2);
        check("b2b_spacing", 32'(((t2 - t1) / 10) >= 168), 32'd1);
        wait_idle(0);
        check("reg7_ff", 32'(dec_regs[0][7]), 32'hFF);
        check("reg0_00", 32'(dec_regs[0][0]), 32'h00);
        check("commits_3", 32'(commits[0]), 32'd3);

        // wr_valid held while busy with wr_addr/wr_data changing every cycle
        do_write(0, 3'd5, 8'h5A, 1'b1, t1);
        n = 0;
        while (n < 3000) begin
            if (ready_v[0]) begin
                valid_v[0] = 1'b0;
                break;
            end
            addr_v[0] = 3'($urandom);
            data_v[0] = 8'($urandom);
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("hold_no_reaccept", 32'(busy_v[0]), 32'd0);
        check("reg5_5a", 32'(dec_regs[0][5]), 32'h5A);
        check("commits_4", 32'(commits[0]), 32'd4);

        // Reset mid-LO after start + 4 data bits
        do_write(0, 3'd3, 8'h99, 1'b0, t1);
        n = 0;
        while (sdo_v[0] !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        r = 0;
        prev = sck_v[0];
        while (r < 5 && n < 300) begin
            @(negedge clk);
            n++;
            if (sck_v[0] && !prev) r++;
            prev = sck_v[0];
        end
        check("abort_reached_bit4", 32'(r), 32'd5);
        @(negedge clk);
        rst_v[0] = 1'b1;
        #1;
        check_reset_outputs(0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("abort_reg3_unchanged", 32'(dec_regs[0][3]), 32'h00);
        check("abort_no_commit", 32'(commits[0]), 32'd4);
        rst_v[0] = 1'b0;
        sync_check(0, 4);
        do_write(0, 3'd3, 8'h66, 1'b0, t1);
        wait_idle(0);
        check("reg3_66", 32'(dec_regs[0][3]), 32'h66);
        check("commits_5", 32'(commits[0]), 32'd5);

        // DUT B: DIV=1
        rst_v[1] = 1'b0;
        sync_check(1, 1);
        do_write(1, 3'd4, 8'h3C, 1'b0, t1);
        check_latency(1, 1);
        wait_idle(1);
        check("b_reg4_3c", 32'(dec_regs[1][4]), 32'h3C);
        check("b_commits_1", 32'(commits[1]), 32'd1);

        repeat (10) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
